// File: rtl/pc_ctrl_unit.sv
// Fetch-stage PC unit: next-PC selection, one-entry stalled-branch redirect slot, AdEL fault flagging.
// Optional accepted-fetch counter is built only when PC_FETCH_CNT_EN is defined.
module pc_ctrl_unit #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = 'h0000_3000,
  parameter logic [ADDR_W-1:0] IMEM_LO    = 'h0000_3000,
  parameter logic [ADDR_W-1:0] IMEM_HI    = 'h0000_4ffc,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc,
  output logic [4:0]        excode_F,
  output logic [ADDR_W-1:0] badvaddr_F,
  output logic              redirect_pending,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;

  slot_t             slot_reg, slot_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] pend_target_reg, pend_target_next;
  logic              fetch_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_reg        <= SLOT_EMPTY;
      pc_reg          <= RESET_PC;
      pend_target_reg <= '0;
    end else begin
      slot_reg        <= slot_next;
      pc_reg          <= pc_next;
      pend_target_reg <= pend_target_next;
    end
  end

  // CP0 redirects ignore the stall; a stalled branch is parked and the newest one wins.
  always_comb begin
    slot_next        = slot_reg;
    pc_next          = pc_reg;
    pend_target_next = pend_target_reg;
    if (exc_req) begin
      pc_next   = EXC_VECTOR;
      slot_next = SLOT_EMPTY;
    end else if (eret_req) begin
      pc_next   = epc;
      slot_next = SLOT_EMPTY;
    end else if (en) begin
      if (br_valid)
        pc_next = br_target;
      else if (slot_reg == SLOT_FULL)
        pc_next = pend_target_reg;
      else
        pc_next = pc_reg + ADDR_W'(4);
      slot_next = SLOT_EMPTY;
    end else if (br_valid) begin
      pend_target_next = br_target;
      slot_next        = SLOT_FULL;
    end
  end

  assign fetch_fault      = (pc_reg[1:0] != 2'b00) || (pc_reg < IMEM_LO) || (pc_reg > IMEM_HI);
  assign pc               = pc_reg;
  assign excode_F         = fetch_fault ? 5'd4 : 5'd0;
  assign badvaddr_F       = fetch_fault ? pc_reg : '0;
  assign redirect_pending = (slot_reg == SLOT_FULL);

`ifdef PC_FETCH_CNT_EN
  logic [31:0] fetch_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset)
      fetch_cnt_reg <= 32'h0;
    else if (en && !exc_req && !eret_req && !fetch_fault)
      fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
  end

  assign fetch_cnt = fetch_cnt_reg;
`else
  assign fetch_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// Self-checking bench for pc_ctrl_unit: directed vector table, counter sequence, and randomized
// traffic against a rule-level reference model. Honours PC_FETCH_CNT_EN for the counter check.
module tb_pc_ctrl_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] LO     = 32'h0000_3000;
  localparam logic [31:0] HI     = 32'h0000_4ffc;
  localparam logic [31:0] VEC    = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset, en, br_valid, exc_req, eret_req;
  logic [31:0] br_target, epc;
  logic [31:0] pc, badvaddr_F, fetch_cnt;
  logic [4:0]  excode_F;
  logic        redirect_pending;

  int checks   = 0;
  int failures = 0;

  pc_ctrl_unit dut (
    .clk(clk), .reset(reset), .en(en), .br_valid(br_valid), .br_target(br_target),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc), .pc(pc), .excode_F(excode_F),
    .badvaddr_F(badvaddr_F), .redirect_pending(redirect_pending), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_pc, m_tgt, m_cnt;
  bit          m_pend;

  function automatic bit faults(input logic [31:0] a);
    return (a % 4 != 0) || (a < LO) || (a > HI);
  endfunction

  task automatic model_step(input bit r, input bit e, input bit b, input logic [31:0] bt,
                            input bit x, input bit er, input logic [31:0] ep);
    if (r) begin
      m_pc = RST_PC; m_pend = 0; m_tgt = 0; m_cnt = 0;
    end else begin
      if (e && !x && !er && !faults(m_pc)) m_cnt = m_cnt + 1;
      if (x)            begin m_pc = VEC; m_pend = 0; end
      else if (er)      begin m_pc = ep;  m_pend = 0; end
      else if (e) begin
        if (b)           m_pc = bt;
        else if (m_pend) m_pc = m_tgt;
        else             m_pc = m_pc + 4;
        m_pend = 0;
      end else if (b)   begin m_tgt = bt; m_pend = 1; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef PC_FETCH_CNT_EN
    return m_cnt;
`else
    return 32'h0;
`endif
  endfunction

  // One transaction: drive, advance the model, clock, then compare every output to the model.
  task automatic step(input bit r, input bit e, input bit b, input logic [31:0] bt,
                      input bit x, input bit er, input logic [31:0] ep);
    reset = r; en = e; br_valid = b; br_target = bt; exc_req = x; eret_req = er; epc = ep;
    model_step(r, e, b, bt, x, er, ep);
    @(posedge clk); #1;
    chk("model_pc", pc, m_pc);
    chk("model_pending", {31'b0, redirect_pending}, {31'b0, m_pend});
    chk("model_excode", {27'b0, excode_F}, faults(m_pc) ? 32'd4 : 32'd0);
    chk("model_badvaddr", badvaddr_F, faults(m_pc) ? m_pc : 32'h0);
    chk("model_fetch_cnt", fetch_cnt, exp_cnt());
    $display("txn rst=%0b en=%0b br=%0b tgt=%h exc=%0b eret=%0b epc=%h -> pc=%h pend=%0b excode=%0d cnt=%0d",
             r, e, b, bt, x, er, ep, pc, redirect_pending, excode_F, fetch_cnt);
  endtask

  typedef struct {
    bit          r, e, b, x, er;
    logic [31:0] bt, ep;
    logic [31:0] exp_pc;
    bit          exp_pend;
    logic [4:0]  exp_code;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit r, bit e, bit b, logic [31:0] bt, bit x, bit er, logic [31:0] ep,
                              logic [31:0] xp, bit xpend, logic [4:0] xc);
    vec_t v;
    v.r = r; v.e = e; v.b = b; v.bt = bt; v.x = x; v.er = er; v.ep = ep;
    v.exp_pc = xp; v.exp_pend = xpend; v.exp_code = xc;
    return v;
  endfunction

  initial begin
    reset = 1; en = 0; br_valid = 0; br_target = 0; exc_req = 0; eret_req = 0; epc = 0;
    m_pc = 0; m_tgt = 0; m_cnt = 0; m_pend = 0;

    //         r  e  b  target        x  er epc           exp_pc        pend code
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 0, 0));
    vt.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 0, 0));
    vt.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, 0, 0));
    vt.push_back(mk(0, 0, 1, 32'h0000_3400, 0, 0, 32'h0,       32'h0000_3008, 1, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, 1, 0));
    vt.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3400, 0, 0));
    vt.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3404, 0, 0));
    vt.push_back(mk(0, 1, 1, 32'h0000_3002, 0, 0, 32'h0,       32'h0000_3002, 0, 4));
    vt.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3006, 0, 4));
    vt.push_back(mk(0, 1, 1, 32'h0000_5000, 0, 0, 32'h0,       32'h0000_5000, 0, 4));
    vt.push_back(mk(0, 1, 1, 32'h0000_2ffc, 0, 0, 32'h0,       32'h0000_2ffc, 0, 4));
    vt.push_back(mk(0, 0, 1, 32'h0000_3100, 0, 0, 32'h0,       32'h0000_2ffc, 1, 4));
    vt.push_back(mk(0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0000_4180, 0, 0));
    vt.push_back(mk(0, 0, 1, 32'h0000_3200, 0, 0, 32'h0,       32'h0000_4180, 1, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_3124, 32'h0000_4180, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_3124, 32'h0000_3124, 0, 0));
    vt.push_back(mk(0, 0, 1, 32'h0000_3300, 0, 0, 32'h0,       32'h0000_3124, 1, 0));
    vt.push_back(mk(1, 1, 1, 32'h0000_3500, 1, 0, 32'h0,       32'h0000_3000, 0, 0));
    vt.push_back(mk(0, 1, 1, 32'h0000_4ffc, 0, 0, 32'h0,       32'h0000_4ffc, 0, 0));
    vt.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_5000, 0, 4));
    vt.push_back(mk(0, 0, 1, 32'h0000_3bbb, 0, 0, 32'h0,       32'h0000_5000, 1, 4));
    vt.push_back(mk(0, 0, 1, 32'h0000_3c00, 0, 0, 32'h0,       32'h0000_5000, 1, 4));
    vt.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3c00, 0, 0));
    vt.push_back(mk(0, 0, 1, 32'h0000_3d00, 0, 0, 32'h0,       32'h0000_3c00, 1, 0));
    vt.push_back(mk(0, 1, 1, 32'h0000_3600, 0, 0, 32'h0,       32'h0000_3600, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_3124, 32'h0000_3124, 0, 0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'hffff_fffc, 32'hffff_fffc, 0, 4));
    vt.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0000, 0, 4));

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].e, vt[i].b, vt[i].bt, vt[i].x, vt[i].er, vt[i].ep);
      chk($sformatf("vec%0d_pc", i), pc, vt[i].exp_pc);
      chk($sformatf("vec%0d_pending", i), {31'b0, redirect_pending}, {31'b0, vt[i].exp_pend});
      chk($sformatf("vec%0d_excode", i), {27'b0, excode_F}, {27'b0, vt[i].exp_code});
      chk($sformatf("vec%0d_badvaddr", i), badvaddr_F, (vt[i].exp_code != 0) ? vt[i].exp_pc : 32'h0);
    end

    // Counter: 10 cycles from reset with two stalls -> 8 accepted fetches when the counter is built.
    begin
      bit pat[10] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
      logic [31:0] want;
      step(1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) step(0, pat[k], 0, 0, 0, 0, 0);
`ifdef PC_FETCH_CNT_EN
      want = 32'd8;
`else
      want = 32'd0;
`endif
      chk("cnt_10_cycles_2_stalls", fetch_cnt, want);
      chk("cnt_seq_pc", pc, 32'h0000_3020);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      logic [31:0] t, ep;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       t = 32'h0000_2ffc;
        1:       t = 32'h0000_5000;
        2:       t = LO + ($urandom_range(0, 32'h7ff) << 2) + $urandom_range(0, 3);
        3:       t = $urandom;
        default: t = LO + ($urandom_range(0, 32'h7ff) << 2);
      endcase
      ep = ($urandom_range(0, 3) == 0) ? $urandom : LO + ($urandom_range(0, 32'h7ff) << 2);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, t,
           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, ep);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
